sha_final_add_stage: RTL and testbench

SHA_FINAL_ADD_STAGE -- requirements
Module: sha_final_add_stage

---
 rtl/sha_final_add_stage.sv | 188 ++++++++++++++++++
 tb/tb_sha_final_add_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_final_add_stage.sv
// sha_final_add_stage: SHA-256 feed-forward add, difficulty compare and hit counter.
//
// Adds the round-63 working state (a..h) to the chaining value (H0..H7) word
// by word, registers the 256-bit compare against a per-block target, and keeps
// a saturating count of hits. Accepts one block per cycle with no stall.
//
// Word indexing: element [n] of state_i, chain_i and digest_o is word n,
// so state_i[0] is a, chain_i[0] is H0 and digest_o[0] is D0. For the compare,
// the digest is read as {D0, D1, ..., D7} with D0 in the most significant bits.
//
// Parameters
//   ADD_PIPELINE_DEPTH  1..2  register stages in the adder (latency = depth + 1)
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   state_i      working state a..h after round 63
//   chain_i      chaining value H0..H7 for the block
//   valid_i      state_i/chain_i/target_i/newblock_i hold a live block
//   newblock_i   tag carried through to newblock_o
//   target_i     256-bit difficulty threshold, captured with the block
//   clear_i      synchronous clear of hit_count_o (wins over a coincident hit)
//   digest_o     final hash words D0..D7, held while no valid block arrives
//   valid_o      digest_o, newblock_o and hit_o are live
//   newblock_o   delayed newblock_i
//   hit_o        digest <= target for the block on digest_o, 0 when not valid
//   hit_count_o  saturating count of hits
module sha_final_add_stage #(
  parameter int unsigned ADD_PIPELINE_DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0][31:0] state_i,
  input  logic [7:0][31:0] chain_i,
  input  logic             valid_i,
  input  logic             newblock_i,
  input  logic [255:0]     target_i,
  input  logic             clear_i,
  output logic [7:0][31:0] digest_o,
  output logic             valid_o,
  output logic             newblock_o,
  output logic             hit_o,
  output logic [15:0]      hit_count_o
);

  localparam int unsigned WORDS  = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned HASH_W = WORDS * WORD_W;
  localparam int unsigned CNT_W  = 16;

  // Completed sums and the sideband that travels with them into the final stage.
  logic [WORDS-1:0][WORD_W-1:0] sum_q;
  logic [HASH_W-1:0]            sum_target_q;
  logic                         sum_valid_q;
  logic                         sum_newblock_q;

  generate
    if (ADD_PIPELINE_DEPTH == 1) begin : g_add_one
      // Single stage: full 32-bit adds, data captured only for live blocks.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_q          <= '0;
          sum_target_q   <= '0;
          sum_valid_q    <= 1'b0;
          sum_newblock_q <= 1'b0;
        end else begin
          sum_valid_q    <= valid_i;
          sum_newblock_q <= newblock_i;
          if (valid_i) begin
            for (int unsigned n = 0; n < WORDS; n++) begin
              sum_q[n] <= state_i[n] + chain_i[n];
            end
            sum_target_q <= target_i;
          end
        end
      end
    end else begin : g_add_two
      // Two stages: low halves plus carry first, high halves completed second.
      logic [WORDS-1:0][HALF_W:0]   lo_c;
      logic [WORDS-1:0][HALF_W:0]   lo_q;
      logic [WORDS-1:0][HALF_W-1:0] state_hi_q;
      logic [WORDS-1:0][HALF_W-1:0] chain_hi_q;
      logic [WORDS-1:0][WORD_W-1:0] full_c;
      logic [HASH_W-1:0]            target_q;
      logic                         valid_q;
      logic                         newblock_q;

      // Low 16-bit sums with their carry out in bit 16.
      always_comb begin
        lo_c = '0;
        for (int unsigned n = 0; n < WORDS; n++) begin
          lo_c[n] = {1'b0, state_i[n][HALF_W-1:0]} + {1'b0, chain_i[n][HALF_W-1:0]};
        end
      end

      // High halves absorb the registered low carry; nothing crosses a word.
      always_comb begin
        full_c = '0;
        for (int unsigned n = 0; n < WORDS; n++) begin
          full_c[n] = {state_hi_q[n] + chain_hi_q[n] + HALF_W'(lo_q[n][HALF_W]),
                       lo_q[n][HALF_W-1:0]};
        end
      end

      // Stage 1: low sums, untouched high halves and the target.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lo_q       <= '0;
          state_hi_q <= '0;
          chain_hi_q <= '0;
          target_q   <= '0;
          valid_q    <= 1'b0;
          newblock_q <= 1'b0;
        end else begin
          valid_q    <= valid_i;
          newblock_q <= newblock_i;
          if (valid_i) begin
            lo_q <= lo_c;
            for (int unsigned n = 0; n < WORDS; n++) begin
              state_hi_q[n] <= state_i[n][WORD_W-1:HALF_W];
              chain_hi_q[n] <= chain_i[n][WORD_W-1:HALF_W];
            end
            target_q <= target_i;
          end
        end
      end

      // Stage 2: completed words.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_q          <= '0;
          sum_target_q   <= '0;
          sum_valid_q    <= 1'b0;
          sum_newblock_q <= 1'b0;
        end else begin
          sum_valid_q    <= valid_q;
          sum_newblock_q <= newblock_q;
          if (valid_q) begin
            sum_q        <= full_c;
            sum_target_q <= target_q;
          end
        end
      end
    end
  endgenerate

  // Digest as one unsigned number, D0 in the top word.
  logic [HASH_W-1:0] sum_cat_c;
  logic              hit_c;

  always_comb begin
    sum_cat_c = '0;
    for (int unsigned n = 0; n < WORDS; n++) begin
      sum_cat_c[HASH_W-1-WORD_W*n -: WORD_W] = sum_q[n];
    end
  end

  assign hit_c = (sum_cat_c <= sum_target_q);

  // Final stage: registered digest and compare; hit is qualified by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digest_o   <= '0;
      valid_o    <= 1'b0;
      newblock_o <= 1'b0;
      hit_o      <= 1'b0;
    end else begin
      valid_o    <= sum_valid_q;
      newblock_o <= sum_newblock_q;
      hit_o      <= sum_valid_q & hit_c;
      if (sum_valid_q) begin
        digest_o <= sum_q;
      end
    end
  end

  // Saturating hit counter; clear takes priority over a hit in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_o <= '0;
    end else if (clear_i) begin
      hit_count_o <= '0;
    end else if (valid_o && hit_o && (hit_count_o != {CNT_W{1'b1}})) begin
      hit_count_o <= hit_count_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sha_final_add_stage.sv
// Scoreboard bench for sha_final_add_stage: one instance per legal adder depth,
// both fed the same stimulus; each has its own expected queue and monitor.
module tb_sha_final_add_stage;

  typedef logic [7:0][31:0] hash_t;

  typedef struct {
    logic [255:0] dig;
    logic         nb;
    logic         hit;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  hash_t        state_i;
  hash_t        chain_i;
  logic         valid_i;
  logic         newblock_i;
  logic [255:0] target_i;
  logic         clear_i;

  hash_t        digest_a, digest_b;
  logic         valid_a, valid_b;
  logic         newblock_a, newblock_b;
  logic         hit_a, hit_b;
  logic [15:0]  count_a, count_b;

  int   checks;
  int   errors;
  int   cyc;
  int   cnt_model [2];
  exp_t q0 [$];
  exp_t q1 [$];

  sha_final_add_stage #(.ADD_PIPELINE_DEPTH(1)) dut_a (
    .clk(clk), .rst(rst), .state_i(state_i), .chain_i(chain_i),
    .valid_i(valid_i), .newblock_i(newblock_i), .target_i(target_i),
    .clear_i(clear_i), .digest_o(digest_a), .valid_o(valid_a),
    .newblock_o(newblock_a), .hit_o(hit_a), .hit_count_o(count_a)
  );

  sha_final_add_stage #(.ADD_PIPELINE_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .state_i(state_i), .chain_i(chain_i),
    .valid_i(valid_i), .newblock_i(newblock_i), .target_i(target_i),
    .clear_i(clear_i), .digest_o(digest_b), .valid_o(valid_b),
    .newblock_o(newblock_b), .hit_o(hit_b), .hit_count_o(count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] cat(input hash_t d);
    logic [255:0] r;
    r = '0;
    for (int n = 0; n < 8; n++) r[255-32*n -: 32] = d[n];
    return r;
  endfunction

  function automatic hash_t add_words(input hash_t s, input hash_t c);
    hash_t r;
    for (int n = 0; n < 8; n++) r[n] = s[n] + c[n];
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, idx, cyc, act, exp);
    end
  endtask

  // One monitor step per falling edge for one instance.
  task automatic mon_step(input int idx, input int lat, input logic vo, input logic nbo,
                          input logic ho, input hash_t dig, input logic [15:0] cnt);
    exp_t e;
    bit   have;
    logic e_hit;
    have  = 1'b0;
    e_hit = 1'b0;
    if (rst) begin
      cnt_model[idx] = 0;
      check("rst_valid", idx, 256'(vo), 256'(0));
      check("rst_newblock", idx, 256'(nbo), 256'(0));
      check("rst_hit", idx, 256'(ho), 256'(0));
      check("rst_count", idx, 256'(cnt), 256'(0));
      check("rst_digest", idx, cat(dig), 256'(0));
      return;
    end
    check("hit_count", idx, 256'(cnt), 256'(cnt_model[idx]));
    if (vo) begin
      if (idx == 0) begin
        have = (q0.size() > 0);
        if (have) e = q0.pop_front();
      end else begin
        have = (q1.size() > 0);
        if (have) e = q1.pop_front();
      end
      if (!have) begin
        check("unexpected_valid", idx, 256'(vo), 256'(0));
      end else begin
        check("digest", idx, cat(dig), e.dig);
        check("newblock", idx, 256'(nbo), 256'(e.nb));
        check("hit", idx, 256'(ho), 256'(e.hit));
        check("latency", idx, 256'(cyc - e.cyc), 256'(lat));
        e_hit = e.hit;
      end
    end else begin
      check("hit_when_idle", idx, 256'(ho), 256'(0));
    end
    if (clear_i) cnt_model[idx] = 0;
    else if (vo && have && e_hit && cnt_model[idx] < 65535) cnt_model[idx]++;
  endtask

  always @(negedge clk) mon_step(0, 2, valid_a, newblock_a, hit_a, digest_a, count_a);
  always @(negedge clk) mon_step(1, 3, valid_b, newblock_b, hit_b, digest_b, count_b);

  // Drive one live block for one cycle and queue its expected result for both instances.
  task automatic send(input hash_t s, input hash_t c, input logic [255:0] t,
                      input logic nb, input hash_t exp_d);
    exp_t e;
    state_i    = s;
    chain_i    = c;
    target_i   = t;
    newblock_i = nb;
    valid_i    = 1'b1;
    e.dig = cat(exp_d);
    e.nb  = nb;
    e.hit = (cat(exp_d) <= t);
    e.cyc = cyc;
    q0.push_back(e);
    q1.push_back(e);
    @(posedge clk);
    #1;
    valid_i    = 1'b0;
    newblock_i = 1'b0;
  endtask

  // Idle cycles with junk on the data lines.
  task automatic idle(input int n, input logic [255:0] t);
    for (int i = 0; i < n; i++) begin
      valid_i    = 1'b0;
      newblock_i = 1'b0;
      target_i   = t;
      for (int w = 0; w < 8; w++) begin
        state_i[w] = $urandom;
        chain_i[w] = $urandom;
      end
      @(posedge clk);
      #1;
    end
  endtask

  hash_t s, c, d, zero_h;
  logic [255:0] t;

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    cnt_model[0] = 0;
    cnt_model[1] = 0;
    rst = 1'b1;
    valid_i = 1'b0;
    newblock_i = 1'b0;
    clear_i = 1'b0;
    state_i = '0;
    chain_i = '0;
    target_i = '0;
    zero_h = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Word wraparound: 1 + 0xFFFFFFFF = 0 in every word, target 0 hits.
    for (int n = 0; n < 8; n++) begin
      s[n] = 32'h0000_0001;
      c[n] = 32'hFFFF_FFFF;
    end
    send(s, c, '0, 1'b1, zero_h);
    idle(4, '0);

    // SHA-256 "abc": round-63 state plus IV.
    s[0] = 32'h506e3058; s[1] = 32'hd39a2165; s[2] = 32'h04d24d6c; s[3] = 32'hb85e2ce9;
    s[4] = 32'h5ef50f24; s[5] = 32'hfb121210; s[6] = 32'h948d25b6; s[7] = 32'h961f4894;
    c[0] = 32'h6a09e667; c[1] = 32'hbb67ae85; c[2] = 32'h3c6ef372; c[3] = 32'ha54ff53a;
    c[4] = 32'h510e527f; c[5] = 32'h9b05688c; c[6] = 32'h1f83d9ab; c[7] = 32'h5be0cd19;
    d[0] = 32'hba7816bf; d[1] = 32'h8f01cfea; d[2] = 32'h414140de; d[3] = 32'h5dae2223;
    d[4] = 32'hb00361a3; d[5] = 32'h96177a9c; d[6] = 32'hb410ff61; d[7] = 32'hf20015ad;
    send(s, c, '0, 1'b0, d);
    idle(4, '1);

    // Low-half carry into the high half: 0x0000FFFF + 0x00000001.
    for (int n = 0; n < 8; n++) begin
      s[n] = 32'h0000_FFFF;
      c[n] = 32'h0000_0001;
      d[n] = 32'h0001_0000;
    end
    send(s, c, '0, 1'b0, d);
    idle(4, '1);

    // Target boundary: equal hits, one below misses, later target change ignored.
    for (int n = 0; n < 8; n++) begin
      s[n] = 32'h1111_0000 + 32'(n);
      c[n] = 32'h0202_0303 * 32'(n + 1);
    end
    d = add_words(s, c);
    t = cat(d);
    send(s, c, t, 1'b0, d);
    send(s, c, t - 256'd1, 1'b0, d);
    send(s, c, t, 1'b0, d);
    idle(1, '0);
    idle(4, '0);

    // Streaming: eight back-to-back blocks, newblock on the first only.
    for (int i = 0; i < 8; i++) begin
      for (int n = 0; n < 8; n++) begin
        s[n] = 32'h0101_0101 * 32'(i + 1) + 32'h0010_0007 * 32'(n);
        c[n] = 32'h9E37_79B9 * 32'(i * 8 + n + 1);
      end
      send(s, c, '0, (i == 0), add_words(s, c));
    end
    idle(6, '1);

    // Reset mid-flight: accepted block is discarded, outputs drop at once.
    state_i = s;
    chain_i = c;
    target_i = '1;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 0, 256'(valid_a), 256'(0));
    check("async_rst_valid", 1, 256'(valid_b), 256'(0));
    check("async_rst_digest", 0, cat(digest_a), 256'(0));
    check("async_rst_digest", 1, cat(digest_b), 256'(0));
    check("async_rst_count", 0, 256'(count_a), 256'(0));
    check("async_rst_count", 1, 256'(count_b), 256'(0));
    check("async_rst_hit", 0, 256'(hit_a), 256'(0));
    check("async_rst_nb", 1, 256'(newblock_b), 256'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(6, '1);

    // Saturation: 0xFFFE preload hits, then three more, then clear against a hit.
    for (int i = 0; i < 65534; i++) send(zero_h, zero_h, '1, 1'b0, zero_h);
    for (int i = 0; i < 3; i++) send(zero_h, zero_h, '1, 1'b0, zero_h);
    idle(5, '1);
    clear_i = 1'b1;
    send(zero_h, zero_h, '1, 1'b0, zero_h);
    idle(3, '1);
    clear_i = 1'b0;
    idle(5, '1);

    // Every queued block must have come out.
    for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    check("drain", 0, 256'(q0.size()), 256'(0));
    check("drain", 1, 256'(q1.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
